// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants and padder FSM types, common to sha1_padder and sha1_core.
package sha1_pkg;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_PAD,
        ST_LEN,
        ST_ISSUE,
        ST_WAIT_DIG
    } pad_state_t;

    // Where ISSUE hands control once the core has taken the block.
    typedef enum logic [1:0] {
        RET_FILL,
        RET_PAD,
        RET_FINAL
    } pad_ret_t;

    localparam logic [7:0] SHA1_PAD_MARK    = 8'h80;
    localparam int         SHA1_LEN_OFS     = 56;
    localparam int         SHA1_BLOCK_BYTES = 64;

    localparam logic [31:0] SHA1_H0 = 32'h67452301;
    localparam logic [31:0] SHA1_H1 = 32'hefcdab89;
    localparam logic [31:0] SHA1_H2 = 32'h98badcfe;
    localparam logic [31:0] SHA1_H3 = 32'h10325476;
    localparam logic [31:0] SHA1_H4 = 32'hc3d2e1f0;

    // Byte k (0 = most significant) of the 64-bit big-endian length field.
    function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] k);
        return len[{~k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sha1_block_buf.sv
// 64-byte write-one-byte-per-cycle buffer; byte i appears at o_flat[511-8i -: 8].
module sha1_block_buf
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_we,
    input  logic [5:0]   i_addr,
    input  logic [7:0]   i_data,
    output logic [511:0] o_flat
);

    logic [SHA1_BLOCK_BYTES-1:0][7:0] r_mem;

    // Byte 0 is the most significant element, so the address is mirrored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[~i_addr] <= i_data;
        end
    end

    assign o_flat = r_mem;

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: byte stream in, padded 512-bit blocks out with init/next pulses.
// Define SHA1_PAD_DONE_EN to add WAIT_DIG and the msg_done output.
module sha1_padder
    import sha1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_valid,
    input  logic [7:0]   s_data,
    input  logic         s_keep,
    input  logic         s_last,
    output logic         s_ready,
    input  logic         core_ready,
    input  logic         core_digest_valid,
    output logic         core_init,
    output logic         core_next,
    output logic [511:0] block
`ifdef SHA1_PAD_DONE_EN
    ,
    output logic         msg_done
`endif
);

    localparam logic [5:0] IDX_LAST = 6'(SHA1_BLOCK_BYTES - 1);
    localparam logic [5:0] IDX_PRE  = 6'(SHA1_LEN_OFS - 1);

    pad_state_t       r_state, w_state_nxt;
    pad_ret_t         r_ret, w_ret_nxt;
    logic [5:0]       r_idx, w_idx_nxt;
    logic [LEN_W-1:0] r_bitlen, w_bitlen_nxt;
    logic             r_first, w_first_nxt;
    logic             r_mark, w_mark_nxt;

    logic             w_acc;
    logic             w_we;
    logic [7:0]       w_wdata;
    logic             w_init;
    logic             w_next;
    logic             w_done;
    logic [63:0]      w_len64;

    assign s_ready = reset_n && (r_state == ST_FILL);
    assign w_acc   = s_valid && s_ready;
    assign w_len64 = 64'(r_bitlen);

    sha1_block_buf u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_we),
        .i_addr  (r_idx),
        .i_data  (w_wdata),
        .o_flat  (block)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_FILL;
            r_ret    <= RET_FILL;
            r_idx    <= '0;
            r_bitlen <= '0;
            r_first  <= 1'b1;
            r_mark   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ret    <= w_ret_nxt;
            r_idx    <= w_idx_nxt;
            r_bitlen <= w_bitlen_nxt;
            r_first  <= w_first_nxt;
            r_mark   <= w_mark_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ret_nxt    = r_ret;
        w_idx_nxt    = r_idx;
        w_bitlen_nxt = r_bitlen;
        w_first_nxt  = r_first;
        w_mark_nxt   = r_mark;
        w_we         = 1'b0;
        w_wdata      = '0;
        w_init       = 1'b0;
        w_next       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            ST_FILL: begin
                if (w_acc) begin
                    if (s_keep) begin
                        w_we         = 1'b1;
                        w_wdata      = s_data;
                        w_idx_nxt    = r_idx + 6'd1;
                        w_bitlen_nxt = r_bitlen + LEN_W'(8);
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_ISSUE;
                            w_ret_nxt   = s_last ? RET_PAD : RET_FILL;
                        end else if (s_last) begin
                            w_state_nxt = ST_PAD;
                        end
                    end else if (s_last) begin
                        // Empty-beat terminator: nothing to store, just close the message.
                        w_state_nxt = ST_PAD;
                    end
                end
            end

            ST_PAD: begin
                w_we       = 1'b1;
                w_wdata    = r_mark ? 8'h00 : SHA1_PAD_MARK;
                w_mark_nxt = 1'b1;
                w_idx_nxt  = r_idx + 6'd1;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_ISSUE;
                    w_ret_nxt   = RET_PAD;
                end else if (r_idx == IDX_PRE) begin
                    w_state_nxt = ST_LEN;
                end
            end

            ST_LEN: begin
                w_we      = 1'b1;
                w_wdata   = len_byte(w_len64, r_idx[2:0]);
                w_idx_nxt = r_idx + 6'd1;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_ISSUE;
                    w_ret_nxt   = RET_FINAL;
                end
            end

            ST_ISSUE: begin
                if (core_ready) begin
                    w_init      = r_first;
                    w_next      = !r_first;
                    w_first_nxt = 1'b0;
                    case (r_ret)
                        RET_PAD: w_state_nxt = ST_PAD;
                        RET_FINAL: begin
                            w_bitlen_nxt = '0;
                            w_idx_nxt    = '0;
                            w_mark_nxt   = 1'b0;
                            w_first_nxt  = 1'b1;
`ifdef SHA1_PAD_DONE_EN
                            w_state_nxt  = ST_WAIT_DIG;
`else
                            w_state_nxt  = ST_FILL;
`endif
                        end
                        default: w_state_nxt = ST_FILL;
                    endcase
                end
            end

            ST_WAIT_DIG: begin
`ifdef SHA1_PAD_DONE_EN
                if (core_digest_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_FILL;
                end
`else
                w_state_nxt = ST_FILL;
`endif
            end

            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Pulses are gated by reset so an asserted reset never leaks an issue.
    assign core_init = reset_n && w_init;
    assign core_next = reset_n && w_next;

`ifdef SHA1_PAD_DONE_EN
    assign msg_done = reset_n && w_done;
`else
    logic w_unused_dig;
    assign w_unused_dig = core_digest_valid ^ w_done;
`endif

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder: a padding model predicts every issued block.
module tb_sha1_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_keep;
    logic         s_last;
    logic         s_ready;
    logic         core_ready;
    logic         core_digest_valid;
    logic         core_init;
    logic         core_next;
    logic [511:0] block;
`ifdef SHA1_PAD_DONE_EN
    logic         msg_done;
`endif

    sha1_padder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .s_valid           (s_valid),
        .s_data            (s_data),
        .s_keep            (s_keep),
        .s_last            (s_last),
        .s_ready           (s_ready),
        .core_ready        (core_ready),
        .core_digest_valid (core_digest_valid),
        .core_init         (core_init),
        .core_next         (core_next),
        .block             (block)
`ifdef SHA1_PAD_DONE_EN
        ,
        .msg_done          (msg_done)
`endif
    );

    typedef struct {
        logic [511:0] blk;
        bit           init;
    } exp_t;

    exp_t         exp_q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_t = 0;
    int           last_issue = 0;
    int           n_init = 0;
    int           n_next = 0;
    logic [511:0] last_blk = '0;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
    localparam logic [511:0] BLK_56_B2 = {448'h0, 64'h1C0};
    localparam logic [511:0] BLK_64_B2 = {8'h80, 440'h0, 64'h200};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Padded message = bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
    task automatic model_push(input logic [7:0] m[$]);
        logic [7:0]  p[$];
        logic [63:0] len;
        p   = m;
        len = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 0; k < 8; k++) p.push_back(len[63-8*k -: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            exp_t e;
            e.blk  = '0;
            for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[64*b+i];
            e.init = (b == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        while (!s_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        last_t = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_keep  = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m[$]);
        for (int i = 0; i < m.size(); i++) send_beat(m[i], 1'b1, i == m.size() - 1);
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d blocks pending expected 0", nm, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]   m[$];
        logic [511:0] b0;
        bit           stable;
        bit           rdy_seen;
        int           pi, pn;

        reset_n           = 1'b0;
        s_valid           = 1'b0;
        s_data            = '0;
        s_keep            = 1'b0;
        s_last            = 1'b0;
        core_ready        = 1'b1;
`ifdef SHA1_PAD_DONE_EN
        core_digest_valid = 1'b1;
`else
        core_digest_valid = 1'b0;
`endif

        // Compare process: every issue pulse must match the next model block.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                #2;
                if (core_init || core_next) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: got init=%0b next=%0b expected none",
                                 core_init, core_next);
                    end else begin
                        e = exp_q.pop_front();
                        chk("block", block, e.blk);
                        chk("pulse_kind", {510'h0, core_init, core_next},
                            e.init ? 512'h2 : 512'h1);
                    end
                    last_blk   = block;
                    last_issue = cyc;
                    if (core_init) n_init++;
                    if (core_next) n_next++;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_s_ready", 512'(s_ready), 512'h0);
        chk("rst_init", 512'(core_init), 512'h0);
        chk("rst_next", 512'(core_next), 512'h0);
        chk("rst_block", block, 512'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("s_ready_after_rst", 512'(s_ready), 512'h1);

        // "abc"
        m = '{8'h61, 8'h62, 8'h63};
        model_push(m);
        send_msg(m);
        wait_drain("abc");
        chk("abc_literal", last_blk, BLK_ABC);
        chk("abc_latency", 512'(last_issue - last_t), 512'd62);
        chk("abc_inits", 512'(n_init), 512'd1);
        chk("abc_nexts", 512'(n_next), 512'd0);

        // Empty message terminator
        m = {};
        model_push(m);
        send_beat(8'h00, 1'b0, 1'b1);
        wait_drain("empty");
        chk("empty_literal", last_blk, BLK_EMPTY);
        chk("empty_latency", 512'(last_issue - last_t), 512'd65);

        // 55 bytes: marker at byte 55, length 0x1B8, no second block
        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'(i + 1));
        model_push(m);
        send_msg(m);
        wait_drain("len55");
        chk("len55_mark", 512'(last_blk[511-8*55 -: 8]), 512'h80);
        chk("len55_len", 512'(last_blk[63:0]), 512'h1B8);
        chk("len55_latency", 512'(last_issue - last_t), 512'd10);

        // 56 bytes: init then next, second block zeros + 0x1C0
        pi = n_init;
        pn = n_next;
        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'(8'hA0 ^ i));
        model_push(m);
        send_msg(m);
        wait_drain("len56");
        chk("len56_b2_literal", last_blk, BLK_56_B2);
        chk("len56_inits", 512'(n_init - pi), 512'd1);
        chk("len56_nexts", 512'(n_next - pn), 512'd1);

        // 64 bytes with core stalled for 100 cycles
        pi = n_init;
        core_ready = 1'b0;
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i));
        model_push(m);
        send_msg(m);
        b0       = block;
        stable   = 1'b1;
        rdy_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (block !== b0) stable = 1'b0;
            if (s_ready) rdy_seen = 1'b1;
        end
        chk("stall_block_stable", 512'(stable), 512'h1);
        chk("stall_s_ready_low", 512'(rdy_seen), 512'h0);
        chk("stall_byte63", 512'(b0[7:0]), 512'h3F);
        chk("stall_no_pulse", 512'(n_init - pi), 512'd0);
        core_ready = 1'b1;
        wait_drain("len64");
        chk("len64_b2_literal", last_blk, BLK_64_B2);

        // Reset in the middle of PAD: nothing may be issued
        pi = n_init;
        pn = n_next;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_s_ready", 512'(s_ready), 512'h0);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("midrst_no_pulse", 512'(n_init - pi + n_next - pn), 512'd0);

        // "abc" with an ignored keep=0 beat in the middle
        m = '{8'h61, 8'h62, 8'h63};
        model_push(m);
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h55, 1'b0, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        wait_drain("abc_again");
        chk("abc_again_literal", last_blk, BLK_ABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
